exec_sequencer: RTL and testbench

//   Multi-cycle control FSM for the single-issue MIPS core. Sequences one instruction

---
 rtl/exec_sequencer.sv | 129 ++++++++++++
 tb/tb_exec_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the single-issue MIPS core
module exec_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  output logic       o_imem_req,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_ALUSrc,
  output logic [5:0] o_ALUop,
  output logic       o_jump,
  output logic       o_beq,
  output logic       o_bne,
  output logic       o_extOp,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_reg_we,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic [2:0] o_state,
  output logic       o_err
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;
  typedef struct packed {
    logic       alusrc;
    logic [5:0] aluop;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       extop;
    logic       regdst;
    logic       memtoreg;
  } ctl_t;
  state_e     state_q, state_d;
  ctl_t       ctl_q, ctl_d, dec;
  logic [5:0] opc_q, opc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       d_r, d_addi, d_slti, d_andi, d_ori, d_lw, d_sw, d_beq, d_bne, d_j, d_legal;
  logic       is_lw, is_sw, is_br, ack, waiting, timeout;
  always_comb begin
    d_r     = i_opcode == 6'b000000;
    d_addi  = i_opcode == 6'b001000;
    d_slti  = i_opcode == 6'b001010;
    d_andi  = i_opcode == 6'b001100;
    d_ori   = i_opcode == 6'b001101;
    d_lw    = i_opcode == 6'b100011;
    d_sw    = i_opcode == 6'b101011;
    d_beq   = i_opcode == 6'b000100;
    d_bne   = i_opcode == 6'b000101;
    d_j     = i_opcode == 6'b000010;
    d_legal = d_r | d_addi | d_slti | d_andi | d_ori | d_lw | d_sw | d_beq | d_bne | d_j;
    dec.alusrc   = d_addi | d_slti | d_andi | d_ori | d_lw | d_sw;
    dec.aluop    = (d_lw | d_sw) ? 6'b001000 : (d_legal && !d_j) ? i_opcode : 6'b000000;
    dec.jump     = d_j;
    dec.beq      = d_beq;
    dec.bne      = d_bne;
    dec.extop    = d_addi | d_slti | d_lw | d_sw | d_beq | d_bne;
    dec.regdst   = d_r;
    dec.memtoreg = d_lw;
  end
  // One timeout counter serves both memory waits; it idles at zero outside FETCH/MEM.
  always_comb begin
    is_lw   = opc_q == 6'b100011;
    is_sw   = opc_q == 6'b101011;
    is_br   = ctl_q.jump | ctl_q.beq | ctl_q.bne;
    ack     = (state_q == FETCH) ? i_imem_ack : i_dmem_ack;
    waiting = state_q == FETCH || state_q == MEM;
    timeout = waiting && !ack && cnt_q == 8'(MEM_TIMEOUT);
    cnt_d   = (waiting && !ack) ? cnt_q + 8'd1 : 8'd0;
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = ack ? DECODE : timeout ? HALT : FETCH;
      DECODE:  state_d = d_legal ? EXEC : HALT;
      EXEC:    state_d = is_br ? FETCH : (is_lw | is_sw) ? MEM : WB;
      MEM:     state_d = ack ? (is_sw ? FETCH : WB) : timeout ? HALT : MEM;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
    opc_d = (state_q == DECODE) ? i_opcode : opc_q;
    ctl_d = (state_q == DECODE && d_legal) ? dec : (state_d == FETCH || state_d == HALT) ? '0 : ctl_q;
    err_d = err_q | (state_d == HALT);
  end
  // Strobes are gated by reset so an aborted instruction never commits anything.
  always_comb begin
    o_imem_req = !i_rst && state_q == FETCH;
    o_ir_we    = !i_rst && state_q == FETCH && i_imem_ack;
    o_pc_we    = !i_rst && ((state_q == EXEC && is_br) || (state_q == MEM && i_dmem_ack && is_sw) || state_q == WB);
    o_dmem_req = !i_rst && state_q == MEM;
    o_dmem_we  = !i_rst && state_q == MEM && is_sw;
    o_reg_we   = !i_rst && state_q == WB;
    o_ALUSrc   = ctl_q.alusrc;
    o_ALUop    = ctl_q.aluop;
    o_jump     = ctl_q.jump;
    o_beq      = ctl_q.beq;
    o_bne      = ctl_q.bne;
    o_extOp    = ctl_q.extop;
    o_regdst   = ctl_q.regdst;
    o_memtoreg = ctl_q.memtoreg;
    o_state    = state_q;
    o_err      = err_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      ctl_q   <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized and directed checks of exec_sequencer against a per-instruction phase model
module tb_exec_sequencer;
  localparam int T = 4;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010;
  logic clk = 1'b0, rst = 1'b1, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic imem_req, ir_we, pc_we, alusrc, jump, beq, bne, extop, dmem_req, dmem_we, reg_we, regdst, memtoreg, err;
  logic [5:0] aluop;
  logic [2:0] state;
  int n_checks = 0, n_fail = 0;
  typedef struct packed {
    logic        rst;
    logic        chk;
    logic        ia;
    logic        da;
    logic [5:0]  op;
    logic [22:0] exp;
  } step_t;
  step_t plan[$];
  logic [22:0] obs[$];
  always #5 clk = ~clk;
  exec_sequencer #(.MEM_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_imem_req(imem_req), .o_ir_we(ir_we), .o_pc_we(pc_we), .o_ALUSrc(alusrc), .o_ALUop(aluop),
    .o_jump(jump), .o_beq(beq), .o_bne(bne), .o_extOp(extop), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_reg_we(reg_we), .o_regdst(regdst), .o_memtoreg(memtoreg),
    .o_state(state), .o_err(err)
  );
  // Control word {ALUSrc, ALUop, jump, beq, bne, extOp, regdst, memtoreg} from the opcode table.
  function automatic logic [12:0] ctl_of(input logic [5:0] op);
    logic a = 1'b0, j = 1'b0, b = 1'b0, n = 1'b0, e = 1'b0, r = 1'b0, m = 1'b0;
    logic [5:0] u = 6'b0;
    case (op)
      OP_R:            begin u = op; r = 1'b1; end
      OP_ADDI, OP_SLTI: begin a = 1'b1; u = op; e = 1'b1; end
      OP_ANDI, OP_ORI:  begin a = 1'b1; u = op; end
      OP_LW:           begin a = 1'b1; e = 1'b1; u = 6'b001000; m = 1'b1; end
      OP_SW:           begin a = 1'b1; e = 1'b1; u = 6'b001000; end
      OP_BEQ:          begin b = 1'b1; e = 1'b1; u = op; end
      OP_BNE:          begin n = 1'b1; e = 1'b1; u = op; end
      OP_J:            j = 1'b1;
      default: ;
    endcase
    return {a, u, j, b, n, e, r, m};
  endfunction
  // Expected outputs {state, imem_req, ir_we, pc_we, dmem_req, dmem_we, reg_we, ctl, err}.
  function automatic logic [22:0] mk(input logic [2:0] st, input logic [5:0] s, input logic [12:0] c, input logic e);
    return {st, s, c, e};
  endfunction
  function automatic logic rb(input bit noise);
    return noise && ($urandom_range(1) == 1);
  endfunction
  function automatic void push(input logic r, input logic ch, input logic a, input logic d,
                               input logic [5:0] op, input logic [22:0] e);
    plan.push_back({r, ch, a, d, op, e});
  endfunction
  function automatic void push_reset();
    push(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 23'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1, 6'($urandom), mk(3'd0, 6'b0, 13'b0, 1'b0));
  endfunction
  function automatic void push_halt(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b1, rb(1'b1), rb(1'b1), 6'($urandom), mk(3'd5, 6'b0, 13'b0, 1'b1));
  endfunction
  // One instruction as phases; iw/dw are wait cycles before ack (> T means never). Returns 1 if it halts.
  function automatic bit build(input logic [5:0] op, input int iw, input int dw, input bit noise);
    logic [12:0] c = ctl_of(op);
    bit lw = op == OP_LW;
    bit sw = op == OP_SW;
    bit br = op == OP_BEQ || op == OP_BNE || op == OP_J;
    bit legal = op inside {OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    for (int k = 0; k <= iw && k <= T; k++)
      push(1'b0, 1'b1, k == iw, rb(noise), noise ? 6'($urandom) : op, mk(3'd0, {1'b1, k == iw, 4'b0}, 13'b0, 1'b0));
    if (iw > T) begin
      push(1'b0, 1'b1, 1'b0, 1'b0, op, mk(3'd5, 6'b0, 13'b0, 1'b1));
      return 1'b1;
    end
    push(1'b0, 1'b1, rb(noise), rb(noise), op, mk(3'd1, 6'b0, 13'b0, 1'b0));
    if (!legal) begin
      push(1'b0, 1'b1, 1'b0, 1'b0, op, mk(3'd5, 6'b0, 13'b0, 1'b1));
      return 1'b1;
    end
    push(1'b0, 1'b1, rb(noise), rb(noise), op, mk(3'd2, {2'b0, br, 3'b0}, c, 1'b0));
    if (br) return 1'b0;
    if (lw || sw) begin
      for (int k = 0; k <= dw && k <= T; k++)
        push(1'b0, 1'b1, rb(noise), k == dw, op, mk(3'd3, {2'b0, sw && k == dw, 1'b1, sw, 1'b0}, c, 1'b0));
      if (dw > T) begin
        push(1'b0, 1'b1, 1'b0, 1'b0, op, mk(3'd5, 6'b0, 13'b0, 1'b1));
        return 1'b1;
      end
      if (sw) return 1'b0;
    end
    push(1'b0, 1'b1, rb(noise), rb(noise), op, mk(3'd4, 6'b001001, c, 1'b0));
    return 1'b0;
  endfunction
  task automatic run();
    obs.delete();
    foreach (plan[i]) begin
      @(negedge clk);
      rst = plan[i].rst;
      imem_ack = plan[i].ia;
      dmem_ack = plan[i].da;
      opcode = plan[i].op;
      #1;
      obs.push_back({state, imem_req, ir_we, pc_we, dmem_req, dmem_we, reg_we,
                     alusrc, aluop, jump, beq, bne, extop, regdst, memtoreg, err});
    end
  endtask
  task automatic test_reset();
    plan.delete();
    push_reset();
    push(1'b0, 1'b1, 1'b0, 1'b0, OP_R, mk(3'd0, 6'b100000, 13'b0, 1'b0));
    push_reset();
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL reset step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_addu();
    plan.delete();
    void'(build(OP_R, 0, 0, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL addu step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_lw_wait();
    plan.delete();
    void'(build(OP_LW, 0, 3, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL lw_wait step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_beq_ori();
    plan.delete();
    void'(build(OP_BEQ, 0, 0, 1'b0));
    void'(build(OP_ORI, 0, 0, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL beq_ori step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_illegal();
    plan.delete();
    void'(build(6'b111111, 0, 0, 1'b0));
    push_halt(3);
    push_reset();
    void'(build(OP_R, 0, 0, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL illegal step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_timeout();
    plan.delete();
    void'(build(OP_R, 9, 0, 1'b0));
    push_halt(1);
    push_reset();
    void'(build(OP_R, T, 0, 1'b0));
    void'(build(OP_LW, 0, 9, 1'b0));
    push_halt(1);
    push_reset();
    void'(build(OP_SW, 0, T, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL timeout step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_reset_mid_sw();
    plan.delete();
    void'(build(OP_SW, 0, 2, 1'b0));
    void'(plan.pop_back());
    push(1'b1, 1'b1, 1'b0, 1'b1, OP_SW, mk(3'd3, 6'b0, ctl_of(OP_SW), 1'b0));
    void'(build(OP_R, 0, 0, 1'b0));
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL reset_mid_sw step%0d: got %h want %h", i, obs[i], plan[i].exp); end
    end
  endtask
  task automatic test_random();
    logic [5:0] ops[10] = '{OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    logic [5:0] op;
    int iw, dw;
    plan.delete();
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 11) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      iw = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, T);
      dw = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, T);
      if (build(op, iw, dw, 1'b1)) begin
        push_halt(2);
        push_reset();
      end
    end
    run();
    foreach (plan[i]) if (plan[i].chk) begin
      n_checks++;
      if (obs[i] !== plan[i].exp) begin n_fail++; $display("FAIL random step%0d op=%b: got %h want %h", i, plan[i].op, obs[i], plan[i].exp); end
    end
  endtask
  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq_ori();
    test_illegal();
    test_timeout();
    test_reset_mid_sw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
